// File: rtl/pll_loop_filter.sv
// Digital PI loop filter for an all-digital PLL: TDC phase error in, DCO control word out.
// Two-stage pipeline (products/integrator, then sum/clamp) plus a consecutive-in-lock counter.
module pll_loop_filter #(
  parameter int TDC_SIZE    = 6,
  parameter int LF_OUT_SIZE = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                          clk_ref,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [15:0]                   kp,
  input  logic [15:0]                   ki,
  input  logic                          err_valid,
  input  logic signed [TDC_SIZE-1:0]    err,
  output logic                          ctrl_valid,
  output logic [LF_OUT_SIZE-1:0]        ctrl,
  output logic                          sat,
  output logic                          lock
);

  // PW: signed err times zero-extended 16-bit gain; IW/SW leave headroom so no sum can overflow
  localparam int PW = TDC_SIZE + 17;
  localparam int IW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;
  localparam int SW = ((IW > LF_OUT_SIZE + 9) ? IW : LF_OUT_SIZE + 9) + 1;
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int EW = TDC_SIZE + 1;

  localparam logic signed [IW-1:0] AMAX = IW'($signed({1'b0, {(ACC_WIDTH-1){1'b1}}}));
  localparam logic signed [IW-1:0] AMIN = IW'($signed({1'b1, {(ACC_WIDTH-1){1'b0}}}));
  localparam logic signed [SW-1:0] MID  = SW'(2 ** (LF_OUT_SIZE - 1));
  localparam logic signed [SW-1:0] OMAX = SW'(2 ** LF_OUT_SIZE - 1);
  localparam logic [LF_OUT_SIZE-1:0] CTRL_RST = LF_OUT_SIZE'(2 ** (LF_OUT_SIZE - 1));
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_COUNT);

  logic                          accept;
  logic [1:0]                    vld_pipe_q;
  logic signed [PW-1:0]          p_term_q, p_term_d;
  logic signed [ACC_WIDTH-1:0]   i_acc_q, i_acc_d;
  logic                          inlk_q, inlk_d;
  logic [LF_OUT_SIZE-1:0]        ctrl_q, ctrl_d;
  logic                          sat_q, sat_d;
  logic                          lock_q, lock_d;
  logic [CW-1:0]                 cnt_q, cnt_d;

  logic signed [PW-1:0]          i_prod;
  logic signed [IW-1:0]          i_sum;
  logic signed [SW-1:0]          tot, sum;
  logic signed [EW-1:0]          err_x, err_mag;

  assign accept = enable & err_valid;

  // Stage 1: products, saturating integrator, in-lock flag for this sample
  always_comb begin
    p_term_d = PW'(err) * PW'($signed({1'b0, kp}));
    i_prod   = PW'(err) * PW'($signed({1'b0, ki}));
    i_sum    = IW'(i_acc_q) + IW'(i_prod);
    if (i_sum > AMAX)      i_acc_d = AMAX[ACC_WIDTH-1:0];
    else if (i_sum < AMIN) i_acc_d = AMIN[ACC_WIDTH-1:0];
    else                   i_acc_d = i_sum[ACC_WIDTH-1:0];
    err_x   = EW'(err);
    err_mag = (err_x < 0) ? -err_x : err_x;
    inlk_d  = (err_mag <= EW'(LOCK_TOL));
  end

  // Stage 2: reads i_acc_q, which already holds this sample's integrator update
  always_comb begin
    tot = SW'(p_term_q) + SW'(i_acc_q);
    sum = (tot >>> 8) + MID;
    if (sum < 0) begin
      ctrl_d = '0;
      sat_d  = 1'b1;
    end else if (sum > OMAX) begin
      ctrl_d = '1;
      sat_d  = 1'b1;
    end else begin
      ctrl_d = sum[LF_OUT_SIZE-1:0];
      sat_d  = 1'b0;
    end
    if (!inlk_q)             cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;
    lock_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      p_term_q   <= '0;
      i_acc_q    <= '0;
      inlk_q     <= 1'b0;
      ctrl_q     <= CTRL_RST;
      sat_q      <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
    end else if (!enable) begin
      vld_pipe_q <= '0;
      p_term_q   <= '0;
      i_acc_q    <= '0;
      inlk_q     <= 1'b0;
      ctrl_q     <= CTRL_RST;
      sat_q      <= 1'b0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], accept};
      if (accept) begin
        p_term_q <= p_term_d;
        i_acc_q  <= i_acc_d;
        inlk_q   <= inlk_d;
      end
      if (vld_pipe_q[0]) begin
        ctrl_q <= ctrl_d;
        sat_q  <= sat_d;
        lock_q <= lock_d;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign ctrl_valid = vld_pipe_q[1];
  assign ctrl       = ctrl_q;
  assign sat        = sat_q;
  assign lock       = lock_q;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed bench for pll_loop_filter; expected values are hand-computed from the PI equations.
module tb_pll_loop_filter;

  logic              clk_ref = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [15:0]       kp = '0;
  logic [15:0]       ki = '0;
  logic              err_valid = 1'b0;
  logic signed [5:0] err = '0;
  logic              ctrl_valid;
  logic [7:0]        ctrl;
  logic              sat;
  logic              lock;

  int n_cmp = 0;
  int n_bad = 0;

  pll_loop_filter dut (
    .clk_ref    (clk_ref),
    .rst        (rst),
    .enable     (enable),
    .kp         (kp),
    .ki         (ki),
    .err_valid  (err_valid),
    .err        (err),
    .ctrl_valid (ctrl_valid),
    .ctrl       (ctrl),
    .sat        (sat),
    .lock       (lock)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one edge with enable low clears the filter
  task automatic clr();
    @(negedge clk_ref) enable = 1'b0;
    @(negedge clk_ref) enable = 1'b1;
  endtask

  // single sample: ctrl_valid must appear exactly two edges after the strobe is driven
  task automatic one(input string tag, input logic signed [5:0] e, input logic [15:0] p,
                     input logic [15:0] i, input int exp_ctrl, input logic exp_sat);
    @(negedge clk_ref);
    err = e; kp = p; ki = i; err_valid = 1'b1;
    @(negedge clk_ref);
    err_valid = 1'b0; kp = 16'hFFFF; ki = 16'hFFFF;
    chk({tag, ".early"}, ctrl_valid, 0);
    @(negedge clk_ref);
    chk({tag, ".vld"},  ctrl_valid, 1);
    chk({tag, ".ctrl"}, ctrl, exp_ctrl);
    chk({tag, ".sat"},  sat, exp_sat);
    @(negedge clk_ref);
    chk({tag, ".pulse"}, ctrl_valid, 0);
    chk({tag, ".hold"},  ctrl, exp_ctrl);
  endtask

  initial begin
    int pulses;
    int bad;
    int wraps;
    logic [23:0] prev, cur;

    #12;
    chk("rst.ctrl", ctrl, 128);
    chk("rst.sat", sat, 0);
    chk("rst.lock", lock, 0);
    chk("rst.vld", ctrl_valid, 0);
    @(negedge clk_ref) begin rst = 1'b0; enable = 1'b1; end

    // proportional path: 5*256 >>> 8 = 5
    one("p.pos", 6'sd5, 16'h0100, 16'h0000, 133, 1'b0);
    clr();
    one("p.neg", -6'sd5, 16'h0100, 16'h0000, 123, 1'b0);
    clr();

    // integral path: 64 per sample, visible at 256
    one("i.s1", 6'sd8, 16'h0000, 16'h0008, 128, 1'b0);
    one("i.s2", 6'sd8, 16'h0000, 16'h0008, 128, 1'b0);
    one("i.s3", 6'sd8, 16'h0000, 16'h0008, 128, 1'b0);
    one("i.s4", 6'sd8, 16'h0000, 16'h0008, 129, 1'b0);
    chk("i.acc", dut.i_acc_q, 256);
    clr();

    // output clamp both ways
    one("sat.hi", 6'sd31, 16'h7FFF, 16'h0000, 255, 1'b1);
    clr();
    one("sat.lo", -6'sd32, 16'h7FFF, 16'h0000, 0, 1'b1);
    clr();
    chk("clr.ctrl", ctrl, 128);
    chk("clr.sat", sat, 0);

    // lock: 16 back-to-back zero errors, then +3 drops it
    pulses = 0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk_ref);
      if (k >= 2) begin
        chk($sformatf("lock.vld%0d", k - 2), ctrl_valid, 1);
        chk($sformatf("lock.lk%0d", k - 2), lock, ((k - 2) == 15) ? 1 : 0);
        if (ctrl_valid) pulses++;
      end
      if (k < 17) begin
        err_valid = 1'b1; kp = '0; ki = '0;
        err = (k == 16) ? 6'sd3 : 6'sd0;
      end else begin
        err_valid = 1'b0;
      end
    end
    @(negedge clk_ref);
    chk("lock.tail", ctrl_valid, 0);
    chk("lock.pulses", pulses, 17);
    chk("lock.held", lock, 0);
    clr();

    // reset one cycle after an accept discards the sample and the integrator
    one("rst.prime", 6'sd5, 16'h0000, 16'h0100, 133, 1'b0);
    @(negedge clk_ref);
    err = 6'sd5; kp = '0; ki = 16'h0100; err_valid = 1'b1;
    @(negedge clk_ref) begin err_valid = 1'b0; rst = 1'b1; end
    @(negedge clk_ref) rst = 1'b0;
    chk("rst.mid.vld", ctrl_valid, 0);
    chk("rst.mid.ctrl", ctrl, 128);
    chk("rst.mid.lock", lock, 0);
    @(negedge clk_ref);
    chk("rst.mid.vld2", ctrl_valid, 0);
    one("rst.restart", 6'sd5, 16'h0000, 16'h0100, 133, 1'b0);

    // same with enable dropped instead
    one("en.prime", 6'sd5, 16'h0000, 16'h0100, 138, 1'b0);
    @(negedge clk_ref);
    err = 6'sd5; kp = '0; ki = 16'h0100; err_valid = 1'b1;
    @(negedge clk_ref) begin err_valid = 1'b0; enable = 1'b0; end
    @(negedge clk_ref) enable = 1'b1;
    chk("en.drop.vld", ctrl_valid, 0);
    chk("en.drop.ctrl", ctrl, 128);
    chk("en.drop.lock", lock, 0);
    @(negedge clk_ref);
    chk("en.drop.vld2", ctrl_valid, 0);
    one("en.restart", 6'sd5, 16'h0000, 16'h0100, 133, 1'b0);
    clr();

    // integrator saturation: 31*65535 per sample, clamps at 2^23-1
    bad = 0; wraps = 0; prev = '0;
    for (int k = 0; k < 602; k++) begin
      @(negedge clk_ref);
      if (k >= 2 && !(ctrl_valid === 1'b1 && ctrl === 8'd255 && sat === 1'b1)) bad++;
      cur = dut.i_acc_q;
      if ($signed(cur) < $signed(prev)) wraps++;
      prev = cur;
      if (k < 600) begin
        err_valid = 1'b1; err = 6'sd31; kp = '0; ki = 16'hFFFF;
      end else begin
        err_valid = 1'b0;
      end
    end
    chk("isat.bad", bad, 0);
    chk("isat.wraps", wraps, 0);
    chk("isat.acc", dut.i_acc_q, 32'h007F_FFFF);
    @(negedge clk_ref);
    chk("isat.ctrl", ctrl, 255);
    chk("isat.sat", sat, 1);
    chk("isat.tail", ctrl_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
